// File: rtl/reg_mask_encoder.sv
// reg_mask_encoder
// Turns a register bitmask (for example a pending-writeback or scoreboard
// mask) into a stream of register indices. Set bits come out lowest index
// first, one index per accepted beat. Both sides use valid/ready handshakes.
// Every output depends only on the state and mask registers, so neither
// in_* nor out_ready has a combinational path to an output.

module reg_mask_encoder #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mask_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic [IDX_W:0]   out_count,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] mask_next;
    logic             done_next;

    logic             accept;
    logic             beat;
    logic [IDX_W-1:0] low_idx;
    logic [IDX_W:0]   pop;
    logic             single;

    // A mask is accepted only in IDLE, so a new mask never overlaps one that is draining.
    assign accept = in_valid && in_ready;
    assign beat   = out_valid && out_ready;

    // Priority encoder over the remaining bits. Bit 0 has the highest priority.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_reg[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Population count of the remaining bits. This value is both out_count
    // and the test for the last beat.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + (IDX_W + 1)'(mask_reg[i]);
        end
    end

    assign single = (pop == (IDX_W + 1)'(1));

    // Next-state logic. Each beat clears the lowest set bit. An empty mask
    // reports done straight away without entering BUSY.
    always_comb begin
        state_next = state;
        mask_next  = mask_reg;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (mask_in != '0) begin
                        mask_next  = mask_in;
                        state_next = BUSY;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (beat) begin
                    mask_next = mask_reg & (mask_reg - WIDTH'(1));
                    if (single) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                mask_next  = '0;
            end
        endcase
    end

    // State, mask and done registers. Reset discards any partly drained
    // mask and suppresses the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mask_reg <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            mask_reg <= mask_next;
            done     <= done_next;
        end
    end

    // Output decode. The index fields are forced to zero whenever no beat is offered.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == BUSY);
        out_index = '0;
        out_last  = 1'b0;
        out_count = '0;
        if (state == BUSY) begin
            out_index = low_idx;
            out_last  = single;
            out_count = pop;
        end
    end

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Directed testbench for reg_mask_encoder. The expected values are worked
// out by hand from the mask patterns in each step.

module tb_reg_mask_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mask_in;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic        out_last;
    logic [5:0]  out_count;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    reg_mask_encoder #(.WIDTH(32), .IDX_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mask_in   (mask_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .out_count (out_count),
        .done      (done)
    );

    // Free-running clock with a 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a mask for exactly one edge. in_valid drops after that edge.
    task automatic applyStimulus(input logic [31:0] m);
        in_valid = 1'b1;
        mask_in  = m;
        step();
        in_valid = 1'b0;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check every output of a valid beat at once
    task automatic checkBeat(input string tag, input int idx, input int cnt, input logic last);
        checkOutput({tag, " valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, " index"}, 32'(out_index), 32'(idx));
        checkOutput({tag, " count"}, 32'(out_count), 32'(cnt));
        checkOutput({tag, " last"},  32'(out_last),  32'(last));
        checkOutput({tag, " done"},  32'(done),      32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mask_in   = '0;
        out_ready = 1'b1;
        #12;

        // Outputs while reset is held
        checkOutput("rst valid", 32'(out_valid), 32'd0);
        checkOutput("rst index", 32'(out_index), 32'd0);
        checkOutput("rst count", 32'(out_count), 32'd0);
        checkOutput("rst last",  32'(out_last),  32'd0);
        checkOutput("rst done",  32'(done),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("rst in_ready", 32'(in_ready), 32'd1);

        // Test 1: two bits at opposite ends of the mask
        applyStimulus(32'h8000_0001);
        checkBeat("t1 b0", 0, 2, 1'b0);
        checkOutput("t1 in_ready busy", 32'(in_ready), 32'd0);
        step();
        checkBeat("t1 b1", 31, 1, 1'b1);
        step();
        checkOutput("t1 done", 32'(done), 32'd1);
        checkOutput("t1 in_ready", 32'(in_ready), 32'd1);
        checkOutput("t1 valid off", 32'(out_valid), 32'd0);
        step();
        checkOutput("t1 done pulse", 32'(done), 32'd0);

        // Test 2: full mask gives 32 back-to-back beats
        applyStimulus(32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            checkBeat($sformatf("t2 b%0d", i), i, 32 - i, (i == 31));
            step();
        end
        checkOutput("t2 done", 32'(done), 32'd1);
        checkOutput("t2 valid off", 32'(out_valid), 32'd0);
        step();

        // Test 3: empty mask reports done one cycle after accept
        applyStimulus(32'h0);
        checkOutput("t3 valid", 32'(out_valid), 32'd0);
        checkOutput("t3 done", 32'(done), 32'd1);
        checkOutput("t3 in_ready", 32'(in_ready), 32'd1);
        step();
        checkOutput("t3 done pulse", 32'(done), 32'd0);
        checkOutput("t3 valid later", 32'(out_valid), 32'd0);

        // Test 4: backpressure holds the beat and blocks new masks
        out_ready = 1'b0;
        applyStimulus(32'h0000_0A00);
        in_valid = 1'b1;
        mask_in  = 32'h0000_FFFF;
        for (int i = 0; i < 5; i++) begin
            checkBeat($sformatf("t4 hold%0d", i), 9, 2, 1'b0);
            checkOutput($sformatf("t4 in_ready%0d", i), 32'(in_ready), 32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkBeat("t4 b0", 9, 2, 1'b0);
        step();
        checkBeat("t4 b1", 11, 1, 1'b1);
        step();
        checkOutput("t4 done", 32'(done), 32'd1);
        step();
        checkOutput("t4 no extra", 32'(out_valid), 32'd0);

        // Test 5: every one-hot mask round-trips to its index
        for (int i = 0; i < 32; i++) begin
            applyStimulus(32'h1 << i);
            checkBeat($sformatf("t5 i%0d", i), i, 1, 1'b1);
            step();
            checkOutput($sformatf("t5 done%0d", i), 32'(done), 32'd1);
        end
        step();

        // Test 6: asynchronous reset in the middle of a drain
        applyStimulus(32'h0000_00F0);
        checkBeat("t6 b0", 4, 4, 1'b0);
        step();
        checkBeat("t6 b1", 5, 3, 1'b0);
        step();
        checkBeat("t6 b2", 6, 2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6 rst valid", 32'(out_valid), 32'd0);
        checkOutput("t6 rst index", 32'(out_index), 32'd0);
        checkOutput("t6 rst count", 32'(out_count), 32'd0);
        checkOutput("t6 rst last",  32'(out_last),  32'd0);
        checkOutput("t6 rst done",  32'(done),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("t6 in_ready", 32'(in_ready), 32'd1);
        checkOutput("t6 no done", 32'(done), 32'd0);
        checkOutput("t6 valid", 32'(out_valid), 32'd0);
        applyStimulus(32'h0000_0002);
        checkBeat("t6 new", 1, 1, 1'b1);
        step();
        checkOutput("t6 new done", 32'(done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
